// File: rtl/tank_shell_if.sv
// Signal bundle between the tank/enemy/collision sources and the shell stage.
// ready high means a fresh fire key on this edge will be considered; fire presses seen while ready is low are dropped, not held.
interface tank_shell_if;
    logic [7:0] keycode;
    logic [9:0] TankX;
    logic [9:0] TankY;
    logic [9:0] TankS;
    logic [1:0] direction;
    logic [9:0] EnemyX;
    logic [9:0] EnemyY;
    logic [9:0] EnemyS;
    logic       barrier_hit;
    logic [9:0] ShellX;
    logic [9:0] ShellY;
    logic [9:0] ShellS;
    logic       shell_active;
    logic       enemy_hit;
    logic       ready;

    modport master (
        output keycode, TankX, TankY, TankS, direction,
        output EnemyX, EnemyY, EnemyS, barrier_hit,
        input  ShellX, ShellY, ShellS, shell_active, enemy_hit, ready
    );

    modport slave (
        input  keycode, TankX, TankY, TankS, direction,
        input  EnemyX, EnemyY, EnemyS, barrier_hit,
        output ShellX, ShellY, ShellS, shell_active, enemy_hit, ready
    );
endinterface

// File: rtl/tank_shell.sv
// Single-shell projectile stage: launches from the tank muzzle on a fresh fire key,
// steps once per frame, retires on enemy/barrier/edge, then waits out a cooldown.
module tank_shell #(
    parameter logic [7:0]  FIRE_KEY   = 8'h2C,
    parameter int unsigned SHELL_STEP = 4,
    parameter int unsigned SHELL_SIZE = 2,
    parameter int unsigned COOLDOWN   = 30,
    parameter int unsigned X_MIN      = 1,
    parameter int unsigned X_MAX      = 639,
    parameter int unsigned Y_MIN      = 1,
    parameter int unsigned Y_MAX      = 479
) (
    input  logic        frame_clk,
    input  logic        Reset,
    tank_shell_if.slave bus,
    output logic [1:0]  state_dbg
);

    localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    localparam logic [10:0] SZ11   = 11'(SHELL_SIZE);
    localparam logic [10:0] STEP11 = 11'(SHELL_STEP);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMIN11 = 11'(Y_MIN);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);
    localparam logic [9:0]  STEP10 = 10'(SHELL_STEP);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLYING   = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    shell_x_q, shell_x_d;
    logic [9:0]    shell_y_q, shell_y_d;
    logic          active_q, active_d;
    logic          hit_q, hit_d;
    logic          key_prev_q;
    logic [1:0]    dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        key_now;
    logic        fire;
    logic [10:0] tank_reach;
    logic [10:0] spawn_x;
    logic [10:0] spawn_y;
    logic        spawn_uflow;
    logic        spawn_ok;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [10:0] enemy_reach;
    logic        overlap;
    logic        leave;
    logic [10:0] x11;
    logic [10:0] y11;

    assign key_now = (bus.keycode == FIRE_KEY);
    assign fire    = key_now && !key_prev_q;

    // Muzzle position; underflow is caught before subtracting so nothing wraps.
    assign tank_reach = {1'b0, bus.TankS} + SZ11;
    always_comb begin
        spawn_uflow = 1'b0;
        spawn_x     = {1'b0, bus.TankX};
        spawn_y     = {1'b0, bus.TankY};
        case (bus.direction)
            2'b00: begin
                if ({1'b0, bus.TankX} < tank_reach + XMIN11) spawn_uflow = 1'b1;
                else spawn_x = {1'b0, bus.TankX} - tank_reach;
            end
            2'b01: spawn_x = {1'b0, bus.TankX} + tank_reach;
            2'b10: spawn_y = {1'b0, bus.TankY} + tank_reach;
            default: begin
                if ({1'b0, bus.TankY} < tank_reach + YMIN11) spawn_uflow = 1'b1;
                else spawn_y = {1'b0, bus.TankY} - tank_reach;
            end
        endcase
    end

    assign spawn_ok = !spawn_uflow
                   && (spawn_x >= XMIN11) && (spawn_x <= XMAX11)
                   && (spawn_y >= YMIN11) && (spawn_y <= YMAX11);

    assign dx = (shell_x_q >= bus.EnemyX) ? (shell_x_q - bus.EnemyX) : (bus.EnemyX - shell_x_q);
    assign dy = (shell_y_q >= bus.EnemyY) ? (shell_y_q - bus.EnemyY) : (bus.EnemyY - shell_y_q);
    assign enemy_reach = {1'b0, bus.EnemyS} + SZ11;
    assign overlap = ({1'b0, dx} <= enemy_reach) && ({1'b0, dy} <= enemy_reach);

    assign x11 = {1'b0, shell_x_q};
    assign y11 = {1'b0, shell_y_q};
    always_comb begin
        case (dir_q)
            2'b00:   leave = x11 < XMIN11 + STEP11 + SZ11;
            2'b01:   leave = x11 + STEP11 + SZ11 > XMAX11;
            2'b10:   leave = y11 + STEP11 + SZ11 > YMAX11;
            default: leave = y11 < YMIN11 + STEP11 + SZ11;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shell_x_d = shell_x_q;
        shell_y_d = shell_y_q;
        active_d  = active_q;
        hit_d     = 1'b0;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fire && spawn_ok) begin
                    shell_x_d = spawn_x[9:0];
                    shell_y_d = spawn_y[9:0];
                    active_d  = 1'b1;
                    dir_d     = bus.direction;
                    state_d   = S_FLYING;
                end
            end
            S_FLYING: begin
                if (overlap || bus.barrier_hit || leave) begin
                    hit_d    = overlap;
                    active_d = 1'b0;
                    cnt_d    = CD_LOAD;
                    state_d  = S_COOLDOWN;
                end else begin
                    case (dir_q)
                        2'b00:   shell_x_d = shell_x_q - STEP10;
                        2'b01:   shell_x_d = shell_x_q + STEP10;
                        2'b10:   shell_y_d = shell_y_q + STEP10;
                        default: shell_y_d = shell_y_q - STEP10;
                    endcase
                end
            end
            S_COOLDOWN: begin
                // The edge that decrements the counter to zero is the IDLE-entry edge.
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            shell_x_q  <= '0;
            shell_y_q  <= '0;
            active_q   <= 1'b0;
            hit_q      <= 1'b0;
            key_prev_q <= 1'b0;
            dir_q      <= 2'b01;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shell_x_q  <= shell_x_d;
            shell_y_q  <= shell_y_d;
            active_q   <= active_d;
            hit_q      <= hit_d;
            key_prev_q <= key_now;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ShellX       = shell_x_q;
    assign bus.ShellY       = shell_y_q;
    assign bus.ShellS       = 10'(SHELL_SIZE);
    assign bus.shell_active = active_q;
    assign bus.enemy_hit    = hit_q;
    assign bus.ready        = (state_q == S_IDLE);
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_tank_shell.sv
// Directed bench for tank_shell: launch, flight, retirement causes, cooldown and reset.
module tb_tank_shell;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [1:0] state_dbg;
    int         n_cmp = 0;
    int         n_err = 0;

    tank_shell_if bus();

    tank_shell dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_defaults();
        bus.keycode     = 8'h00;
        bus.TankX       = 10'd160;
        bus.TankY       = 10'd240;
        bus.TankS       = 10'd8;
        bus.direction   = 2'b01;
        bus.EnemyX      = 10'd600;
        bus.EnemyY      = 10'd40;
        bus.EnemyS      = 10'd8;
        bus.barrier_hit = 1'b0;
    endtask

    // Bounded wait for the return to IDLE.
    task automatic wait_ready(input string tag);
        for (int i = 0; i < 64 && bus.ready !== 1'b1; i++) step();
        n_cmp++;
        if (bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_wait_ready: ready=%b want 1 within 64 frames", tag, bus.ready);
        end
    endtask

    task automatic test_reset();
        set_defaults();
        Reset = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (bus.shell_active !== 1'b0 || bus.enemy_hit !== 1'b0 || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_flags: active=%b hit=%b ready=%b want 0 0 1",
                     bus.shell_active, bus.enemy_hit, bus.ready);
        end
        n_cmp++;
        if (bus.ShellX !== 10'd0 || bus.ShellY !== 10'd0 || bus.ShellS !== 10'd2) begin
            n_err++;
            $display("FAIL reset_pos: x=%0d y=%0d s=%0d want 0 0 2", bus.ShellX, bus.ShellY, bus.ShellS);
        end
        Reset = 1'b0;
        step();
        n_cmp++;
        if (state_dbg !== 2'd0 || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: state=%0d ready=%b want 0 1", state_dbg, bus.ready);
        end
    endtask

    task automatic test_right_flight();
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        n_cmp++;
        if (bus.ShellX !== 10'd170 || bus.ShellY !== 10'd240 || bus.shell_active !== 1'b1 || bus.ready !== 1'b0) begin
            n_err++;
            $display("FAIL right_spawn: x=%0d y=%0d act=%b rdy=%b want 170 240 1 0",
                     bus.ShellX, bus.ShellY, bus.shell_active, bus.ready);
        end
        for (int k = 1; k <= 116; k++) begin
            step();
            n_cmp++;
            if (bus.ShellX !== 10'(170 + 4 * k) || bus.shell_active !== 1'b1) begin
                n_err++;
                $display("FAIL right_move%0d: x=%0d act=%b want %0d 1", k, bus.ShellX, bus.shell_active, 170 + 4 * k);
            end
        end
        step();
        n_cmp++;
        if (bus.shell_active !== 1'b0 || bus.ShellX !== 10'd634 || bus.enemy_hit !== 1'b0 || state_dbg !== 2'd2) begin
            n_err++;
            $display("FAIL right_retire: act=%b x=%0d hit=%b state=%0d want 0 634 0 2",
                     bus.shell_active, bus.ShellX, bus.enemy_hit, state_dbg);
        end
        repeat (29) step();
        n_cmp++;
        if (bus.ready !== 1'b0) begin
            n_err++;
            $display("FAIL cooldown_29: ready=%b want 0", bus.ready);
        end
        step();
        n_cmp++;
        if (bus.ready !== 1'b1 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL cooldown_30: ready=%b state=%0d want 1 0", bus.ready, state_dbg);
        end
    endtask

    task automatic test_enemy_hit();
        bus.EnemyX = 10'd200;
        bus.EnemyY = 10'd240;
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            n_cmp++;
            if (bus.ShellX !== 10'(170 + 4 * k) || bus.enemy_hit !== 1'b0 || bus.shell_active !== 1'b1) begin
                n_err++;
                $display("FAIL hit_approach%0d: x=%0d hit=%b act=%b want %0d 0 1",
                         k, bus.ShellX, bus.enemy_hit, bus.shell_active, 170 + 4 * k);
            end
        end
        step();
        n_cmp++;
        if (bus.enemy_hit !== 1'b1 || bus.shell_active !== 1'b0 || bus.ShellX !== 10'd190) begin
            n_err++;
            $display("FAIL hit_pulse: hit=%b act=%b x=%0d want 1 0 190", bus.enemy_hit, bus.shell_active, bus.ShellX);
        end
        step();
        n_cmp++;
        if (bus.enemy_hit !== 1'b0) begin
            n_err++;
            $display("FAIL hit_one_cycle: hit=%b want 0", bus.enemy_hit);
        end
        wait_ready("hit");
        set_defaults();
    endtask

    task automatic test_key_hold();
        int   launches = 0;
        logic prev_act = 1'b0;
        bus.EnemyX = 10'd200;
        bus.EnemyY = 10'd240;
        bus.keycode = 8'h2C;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.shell_active === 1'b1 && prev_act === 1'b0) launches++;
            prev_act = bus.shell_active;
        end
        n_cmp++;
        if (launches != 1 || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_once: launches=%0d ready=%b want 1 1", launches, bus.ready);
        end
        bus.keycode = 8'h00;
        step();
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        n_cmp++;
        if (bus.shell_active !== 1'b1) begin
            n_err++;
            $display("FAIL repress_launch: act=%b want 1", bus.shell_active);
        end
        for (int i = 0; i < 20 && bus.enemy_hit !== 1'b1; i++) step();
        n_cmp++;
        if (bus.enemy_hit !== 1'b1) begin
            n_err++;
            $display("FAIL repress_hit: hit=%b want 1 within 20 frames", bus.enemy_hit);
        end
        step();
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        step();
        n_cmp++;
        if (bus.shell_active !== 1'b0 || bus.ready !== 1'b0 || state_dbg !== 2'd2) begin
            n_err++;
            $display("FAIL cooldown_drop: act=%b rdy=%b state=%0d want 0 0 2", bus.shell_active, bus.ready, state_dbg);
        end
        wait_ready("hold");
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        n_cmp++;
        if (bus.shell_active !== 1'b1 || bus.ShellX !== 10'd170) begin
            n_err++;
            $display("FAIL after_ready_launch: act=%b x=%0d want 1 170", bus.shell_active, bus.ShellX);
        end
        for (int i = 0; i < 20 && bus.shell_active === 1'b1; i++) step();
        wait_ready("hold2");
        set_defaults();
    endtask

    task automatic test_underflow();
        bus.direction = 2'b00;
        bus.TankX = 10'd10;
        bus.keycode = 8'h2C;
        step();
        n_cmp++;
        if (bus.shell_active !== 1'b0 || bus.ready !== 1'b1 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL underflow_suppress: act=%b rdy=%b state=%0d want 0 1 0", bus.shell_active, bus.ready, state_dbg);
        end
        repeat (3) step();
        bus.keycode = 8'h00;
        step();
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.shell_active !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_idle: rdy=%b act=%b want 1 0", bus.ready, bus.shell_active);
        end
        // One pixel further right the muzzle lands exactly on X_MIN.
        bus.TankX = 10'd11;
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        n_cmp++;
        if (bus.shell_active !== 1'b1 || bus.ShellX !== 10'd1 || bus.ShellY !== 10'd240) begin
            n_err++;
            $display("FAIL left_edge_spawn: act=%b x=%0d y=%0d want 1 1 240", bus.shell_active, bus.ShellX, bus.ShellY);
        end
        step();
        n_cmp++;
        if (bus.shell_active !== 1'b0 || bus.ShellX !== 10'd1) begin
            n_err++;
            $display("FAIL left_edge_retire: act=%b x=%0d want 0 1", bus.shell_active, bus.ShellX);
        end
        wait_ready("underflow");
        set_defaults();
    endtask

    task automatic test_barrier();
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        step();
        bus.barrier_hit = 1'b1;
        step();
        bus.barrier_hit = 1'b0;
        n_cmp++;
        if (bus.shell_active !== 1'b0 || bus.enemy_hit !== 1'b0 || bus.ShellX !== 10'd174 || state_dbg !== 2'd2) begin
            n_err++;
            $display("FAIL barrier_retire: act=%b hit=%b x=%0d state=%0d want 0 0 174 2",
                     bus.shell_active, bus.enemy_hit, bus.ShellX, state_dbg);
        end
        wait_ready("barrier");
    endtask

    task automatic test_priority_turn();
        bus.EnemyX = 10'd200;
        bus.EnemyY = 10'd240;
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        step();
        bus.direction = 2'b11;
        step();
        n_cmp++;
        if (bus.ShellX !== 10'd178 || bus.ShellY !== 10'd240) begin
            n_err++;
            $display("FAIL turn_ignored: x=%0d y=%0d want 178 240", bus.ShellX, bus.ShellY);
        end
        repeat (3) step();
        n_cmp++;
        if (bus.ShellX !== 10'd190 || bus.ShellY !== 10'd240 || bus.shell_active !== 1'b1) begin
            n_err++;
            $display("FAIL turn_steps: x=%0d y=%0d act=%b want 190 240 1", bus.ShellX, bus.ShellY, bus.shell_active);
        end
        bus.barrier_hit = 1'b1;
        step();
        bus.barrier_hit = 1'b0;
        n_cmp++;
        if (bus.enemy_hit !== 1'b1 || bus.shell_active !== 1'b0) begin
            n_err++;
            $display("FAIL priority_hit: hit=%b act=%b want 1 0", bus.enemy_hit, bus.shell_active);
        end
        step();
        n_cmp++;
        if (bus.enemy_hit !== 1'b0) begin
            n_err++;
            $display("FAIL priority_pulse: hit=%b want 0", bus.enemy_hit);
        end
        set_defaults();
        wait_ready("priority");
    endtask

    task automatic test_reset_midflight();
        bus.TankX = 10'd290;
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        n_cmp++;
        if (bus.ShellX !== 10'd300 || bus.ShellY !== 10'd240 || bus.shell_active !== 1'b1) begin
            n_err++;
            $display("FAIL mid_spawn: x=%0d y=%0d act=%b want 300 240 1", bus.ShellX, bus.ShellY, bus.shell_active);
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.shell_active !== 1'b0 || bus.ShellX !== 10'd0 || bus.ready !== 1'b1 || bus.enemy_hit !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_reset: act=%b x=%0d rdy=%b hit=%b want 0 0 1 0",
                     bus.shell_active, bus.ShellX, bus.ready, bus.enemy_hit);
        end
        step();
        n_cmp++;
        if (bus.ShellX !== 10'd0 || bus.ShellY !== 10'd0 || bus.enemy_hit !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_hold: x=%0d y=%0d hit=%b want 0 0 0", bus.ShellX, bus.ShellY, bus.enemy_hit);
        end
        Reset = 1'b0;
        step();
        n_cmp++;
        if (state_dbg !== 2'd0 || bus.ready !== 1'b1 || bus.shell_active !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release: state=%0d rdy=%b act=%b want 0 1 0", state_dbg, bus.ready, bus.shell_active);
        end
        set_defaults();
    endtask

    initial begin
        test_reset();
        test_right_flight();
        test_enemy_hit();
        test_key_hold();
        test_underflow();
        test_barrier();
        test_priority_turn();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
